// File: rtl/stream_split.sv
`default_nettype none
// ============================================================================
// stream_split : one-to-two valid/ready splitter with per-beat destination
// mask (fork / unicast / drop) and a one-entry register slice per output.
// Revision 1.0
// ============================================================================
module stream_split #(
  parameter int DATA_WD = 4,
  parameter int CNT_WD  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2*DATA_WD-1:0] c_data,
  input  logic [1:0]           c_dst,
  input  logic                 c_valid,
  output logic                 c_ready,
  output logic [DATA_WD-1:0]   a_data,
  output logic                 a_valid,
  input  logic                 a_ready,
  output logic [DATA_WD-1:0]   b_data,
  output logic                 b_valid,
  input  logic                 b_ready,
  output logic [CNT_WD-1:0]    drop_cnt
);

  localparam logic [CNT_WD-1:0] DROP_MAX = {CNT_WD{1'b1}};

  logic [DATA_WD-1:0] a_data_q, a_data_d;
  logic [DATA_WD-1:0] b_data_q, b_data_d;
  logic               a_valid_q, a_valid_d;
  logic               b_valid_q, b_valid_d;
  logic [CNT_WD-1:0]  drop_cnt_q, drop_cnt_d;

  logic a_can;
  logic b_can;
  logic c_fire;

  assign a_can   = !a_valid_q || a_ready;
  assign b_can   = !b_valid_q || b_ready;
  // A fork needs both slices free in the same cycle, so neither branch loads alone.
  assign c_ready = !rst && (!c_dst[0] || a_can) && (!c_dst[1] || b_can);
  assign c_fire  = c_valid && c_ready;

  always_comb begin
    a_data_d   = a_data_q;
    a_valid_d  = a_valid_q;
    b_data_d   = b_data_q;
    b_valid_d  = b_valid_q;
    drop_cnt_d = drop_cnt_q;

    if (a_valid_q && a_ready) a_valid_d = 1'b0;
    if (b_valid_q && b_ready) b_valid_d = 1'b0;

    if (c_fire && c_dst[0]) begin
      a_data_d  = c_data[2*DATA_WD-1:DATA_WD];
      a_valid_d = 1'b1;
    end
    if (c_fire && c_dst[1]) begin
      b_data_d  = c_data[DATA_WD-1:0];
      b_valid_d = 1'b1;
    end

    if (c_fire && (c_dst == 2'b00) && (drop_cnt_q != DROP_MAX))
      drop_cnt_d = drop_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_data_q   <= '0;
      a_valid_q  <= 1'b0;
      b_data_q   <= '0;
      b_valid_q  <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      a_data_q   <= a_data_d;
      a_valid_q  <= a_valid_d;
      b_data_q   <= b_data_d;
      b_valid_q  <= b_valid_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign a_data   = a_data_q;
  assign a_valid  = a_valid_q;
  assign b_data   = b_data_q;
  assign b_valid  = b_valid_q;
  assign drop_cnt = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_stream_split.sv
`default_nettype none
// ============================================================================
// tb_stream_split : directed vector table plus corner sequences and a soak.
// Revision 1.0
// ============================================================================
module tb_stream_split;

  logic       clk;
  logic       rst;
  logic [7:0] c_data;
  logic [1:0] c_dst;
  logic       c_valid;
  logic       c_ready;
  logic [3:0] a_data;
  logic       a_valid;
  logic       a_ready;
  logic [3:0] b_data;
  logic       b_valid;
  logic       b_ready;
  logic [7:0] drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  stream_split #(.DATA_WD(4), .CNT_WD(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .c_data  (c_data),
    .c_dst   (c_dst),
    .c_valid (c_valid),
    .c_ready (c_ready),
    .a_data  (a_data),
    .a_valid (a_valid),
    .a_ready (a_ready),
    .b_data  (b_data),
    .b_valid (b_valid),
    .b_ready (b_ready),
    .drop_cnt(drop_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic       rst;
    logic       cv;
    logic [1:0] dst;
    logic [7:0] data;
    logic       ar;
    logic       br;
    logic       exp_cr;
    logic       exp_av;
    logic [3:0] exp_ad;
    logic       exp_bv;
    logic [3:0] exp_bd;
    logic [7:0] exp_drop;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic cv, input logic [1:0] dst,
                       input logic [7:0] d, input logic ar, input logic br);
    rst     = r;
    c_valid = cv;
    c_dst   = dst;
    c_data  = d;
    a_ready = ar;
    b_ready = br;
  endtask

  // soak model and scoreboard state
  logic       m_av, m_bv, m_fire, exp_cr;
  logic [3:0] m_ad, m_bd, exp_d;
  logic [7:0] m_drop;
  logic [3:0] qa[$];
  logic [3:0] qb[$];
  int soak_err, acc_a, acc_b, emit_a, emit_b;
  int flow_err;

  initial begin
    drive(1'b1, 1'b0, 2'b00, 8'h00, 1'b1, 1'b1);

    // {rst, c_valid, dst, data, a_ready, b_ready, exp c_ready, exp a_valid/a_data, b_valid/b_data, drop}
    vecs[0]  = '{1'b1, 1'b1, 2'b11, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 8'd0};
    vecs[1]  = '{1'b0, 1'b1, 2'b11, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 4'hA, 1'b1, 4'h5, 8'd0};
    vecs[2]  = '{1'b0, 1'b0, 2'b00, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 4'hA, 1'b0, 4'h5, 8'd0};
    vecs[3]  = '{1'b0, 1'b1, 2'b01, 8'h70, 1'b0, 1'b1, 1'b1, 1'b1, 4'h7, 1'b0, 4'h5, 8'd0};
    vecs[4]  = '{1'b0, 1'b1, 2'b11, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b1, 4'h7, 1'b0, 4'h5, 8'd0};
    vecs[5]  = '{1'b0, 1'b1, 2'b11, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 4'h3, 1'b1, 4'hC, 8'd0};
    vecs[6]  = '{1'b0, 1'b0, 2'b00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 4'h3, 1'b1, 4'hC, 8'd0};
    vecs[7]  = '{1'b0, 1'b1, 2'b10, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 4'h3, 1'b1, 4'hC, 8'd0};
    vecs[8]  = '{1'b0, 1'b1, 2'b00, 8'h99, 1'b0, 1'b0, 1'b1, 1'b0, 4'h3, 1'b1, 4'hC, 8'd1};
    vecs[9]  = '{1'b0, 1'b1, 2'b10, 8'h12, 1'b0, 1'b1, 1'b1, 1'b0, 4'h3, 1'b1, 4'h2, 8'd1};
    vecs[10] = '{1'b0, 1'b1, 2'b01, 8'h45, 1'b0, 1'b1, 1'b1, 1'b1, 4'h4, 1'b0, 4'h2, 8'd1};

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].cv, vecs[i].dst, vecs[i].data, vecs[i].ar, vecs[i].br);
      #1;
      chk($sformatf("v%0d_c_ready", i), c_ready, vecs[i].exp_cr);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_a_valid", i), a_valid, vecs[i].exp_av);
      chk($sformatf("v%0d_a_data", i), a_data, vecs[i].exp_ad);
      chk($sformatf("v%0d_b_valid", i), b_valid, vecs[i].exp_bv);
      chk($sformatf("v%0d_b_data", i), b_data, vecs[i].exp_bd);
      chk($sformatf("v%0d_drop_cnt", i), drop_cnt, vecs[i].exp_drop);
    end

    // unicast to b while a is stalled holding 4'h4
    for (int i = 0; i < 4; i++) begin
      logic [7:0] d;
      d = 8'hF1 + 8'(i);
      @(negedge clk);
      drive(1'b0, 1'b1, 2'b10, d, 1'b0, 1'b1);
      #1;
      chk($sformatf("uni%0d_c_ready", i), c_ready, 1'b1);
      @(posedge clk);
      #1;
      chk($sformatf("uni%0d_b_data", i), b_data, d[3:0]);
      chk($sformatf("uni%0d_b_valid", i), b_valid, 1'b1);
      chk($sformatf("uni%0d_a_data", i), a_data, 4'h4);
      chk($sformatf("uni%0d_a_valid", i), a_valid, 1'b1);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 2'b00, 8'h00, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    chk("drain_a_valid", a_valid, 1'b0);
    chk("drain_b_valid", b_valid, 1'b0);

    // drop saturation from a clean reset
    @(negedge clk);
    drive(1'b1, 1'b0, 2'b00, 8'h00, 1'b1, 1'b1);
    flow_err = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      drive(1'b0, 1'b1, 2'b00, 8'(i), 1'b0, 1'b0);
      #1;
      if (c_ready !== 1'b1) flow_err++;
      @(posedge clk);
      #1;
      if (a_valid !== 1'b0 || b_valid !== 1'b0) flow_err++;
      if (drop_cnt !== ((i + 1 > 255) ? 8'd255 : 8'(i + 1))) flow_err++;
      if (i == 253) chk("drop_cnt_254", drop_cnt, 8'd254);
    end
    chk("drop_flow_errs", flow_err, 0);
    chk("drop_cnt_sat", drop_cnt, 8'd255);

    // reset while both slices are stalled
    @(negedge clk);
    drive(1'b0, 1'b1, 2'b11, 8'h6B, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("prerst_a_valid", a_valid, 1'b1);
    chk("prerst_b_data", b_data, 4'hB);
    @(negedge clk);
    drive(1'b1, 1'b1, 2'b11, 8'hEE, 1'b0, 1'b0);
    #1;
    chk("rst_c_ready", c_ready, 1'b0);
    @(posedge clk);
    #1;
    chk("rst_a_valid", a_valid, 1'b0);
    chk("rst_b_valid", b_valid, 1'b0);
    chk("rst_a_data", a_data, 4'h0);
    chk("rst_b_data", b_data, 4'h0);
    chk("rst_drop_cnt", drop_cnt, 8'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 2'b00, 8'h00, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    chk("postrst_a_valid", a_valid, 1'b0);
    chk("postrst_b_valid", b_valid, 1'b0);

    // random soak: slice model plus per-output in-order scoreboard
    m_av = 1'b0; m_bv = 1'b0; m_ad = 4'h0; m_bd = 4'h0; m_drop = 8'd0;
    soak_err = 0; acc_a = 0; acc_b = 0; emit_a = 0; emit_b = 0;
    for (int i = 0; i < 504; i++) begin
      @(negedge clk);
      if (i < 500)
        drive(1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else
        drive(1'b0, 1'b0, 2'b00, 8'h00, 1'b1, 1'b1);
      #1;
      exp_cr = (!c_dst[0] || !m_av || a_ready) && (!c_dst[1] || !m_bv || b_ready);
      if (c_ready !== exp_cr) soak_err++;
      if (a_valid && a_ready) begin
        emit_a++;
        if (qa.size() == 0) soak_err++;
        else begin
          exp_d = qa.pop_front();
          if (a_data !== exp_d) soak_err++;
        end
      end
      if (b_valid && b_ready) begin
        emit_b++;
        if (qb.size() == 0) soak_err++;
        else begin
          exp_d = qb.pop_front();
          if (b_data !== exp_d) soak_err++;
        end
      end
      m_fire = c_valid && exp_cr;
      if (m_av && a_ready) m_av = 1'b0;
      if (m_bv && b_ready) m_bv = 1'b0;
      if (m_fire && c_dst[0]) begin
        m_av = 1'b1; m_ad = c_data[7:4]; qa.push_back(c_data[7:4]); acc_a++;
      end
      if (m_fire && c_dst[1]) begin
        m_bv = 1'b1; m_bd = c_data[3:0]; qb.push_back(c_data[3:0]); acc_b++;
      end
      if (m_fire && c_dst == 2'b00 && m_drop != 8'd255) m_drop = m_drop + 8'd1;
      @(posedge clk);
      #1;
      if (a_valid !== m_av || b_valid !== m_bv || drop_cnt !== m_drop) soak_err++;
      if (m_av && a_data !== m_ad) soak_err++;
      if (m_bv && b_data !== m_bd) soak_err++;
    end
    chk("soak_errs", soak_err, 0);
    chk("soak_a_acc_vs_emit", emit_a, acc_a);
    chk("soak_b_acc_vs_emit", emit_b, acc_b);
    chk("soak_drop_cnt", drop_cnt, m_drop);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stream_split.md
Name: stream_split

Overview:
- Splitter/fork for AXI-stream-style valid/ready traffic: the partner of the two-into-one join/mux.
- Takes one input stream `c` carrying a 2*DATA_WD concatenated word and routes it to two DATA_WD output streams `a` and `b`.
- A per-beat destination mask selects the route: broadcast fork (both), unicast (a only or b only), or drop.
- Each output has its own one-entry register slice, so the two consumers are decoupled and the path runs at full throughput.

Parameters:
- DATA_WD, 4, width of each output payload; input payload is 2*DATA_WD.
- CNT_WD, 8, width of the saturating drop counter.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- c_data  in  2*DATA_WD  input payload; [2*DATA_WD-1:DATA_WD] goes to a, [DATA_WD-1:0] goes to b.
- c_dst  in  2  destination mask, qualified by c_valid; bit0 = a, bit1 = b.
- c_valid  in  1  input beat valid.
- c_ready  out  1  input beat accepted this cycle when c_valid && c_ready (c_fire).
- a_data  out  DATA_WD  output a payload.
- a_valid  out  1  output a valid.
- a_ready  in  1  output a ready.
- b_data  out  DATA_WD  output b payload.
- b_valid  out  1  output b valid.
- b_ready  in  1  output b ready.
- drop_cnt  out  CNT_WD  count of beats accepted with c_dst=2'b00; saturating.

Behaviour:
- Reset: rst is sampled on posedge clk only.
  - While rst=1: c_ready=0 (combinationally forced); a_valid=b_valid=0; a_data=b_data=0; drop_cnt=0.
  - rst asserted mid-transfer discards both slice contents; any beat presented in that cycle is not accepted.
- Per-branch load enable: a_can = !a_valid || a_ready; b_can = !b_valid || b_ready.
- c_ready = !rst && (!c_dst[0] || a_can) && (!c_dst[1] || b_can).
  - c_ready may depend on c_dst and on a_ready/b_ready combinationally.
  - No combinational path exists from c_valid to a_valid or b_valid.
- On c_fire:
  - If c_dst[0]: a_data <= upper half, a_valid <= 1.
  - If c_dst[1]: b_data <= lower half, b_valid <= 1.
  - Unselected branch: slice keeps its current content and handshake.
  - Latency is 1 cycle from c_fire to x_valid.
- Fork is all-or-nothing: a beat with c_dst=2'b11 is accepted only in a cycle where both slices can load. It never partially loads and never duplicates a branch.
- Per-branch slice state, without c_fire loading that branch:
  - x_valid && x_ready: x_valid <= 0.
  - x_valid && !x_ready: x_data and x_valid hold stable (no change while stalled).
- Same-cycle events:
  - x_fire and a load into the same slice in one cycle: the new beat is loaded and x_valid stays 1.
  - Full throughput is 1 beat/cycle per branch while the consumer holds ready=1.
- Drop (c_dst=2'b00): c_ready=1 regardless of slice state; the beat is consumed and no output asserts.
  - drop_cnt increments by 1 per dropped beat.
  - drop_cnt saturates at 2^CNT_WD-1 (255 by default) and does not wrap.
- Ordering: each output emits its selected beats in input order. There is no ordering guarantee between a and b.
- Data while x_valid=0 is don't-care, but the implementation holds the last value.

Test Plan:
- Reset then fork: c_dst=2'b11, c_data=8'hA5, a_ready=b_ready=1 -> c_ready=1; next cycle a_data=4'hA, b_data=4'h5, a_valid=b_valid=1 for one cycle.
- Fork backpressure: a_valid=1, a_ready=0, b slice empty, present c_dst=2'b11, c_data=8'h3C -> c_ready=0 and the b slice does not load; raise a_ready -> accepted, next cycle a_data=4'h3, b_data=4'hC.
- Unicast bypass: a stalled (a_valid=1, a_ready=0), stream 4 beats with c_dst=2'b10, b_ready=1 -> c_ready=1 each cycle, b_data sequence equals the low nibbles in order, a_data unchanged.
- Drop and saturation: 300 beats with c_dst=2'b00 -> c_ready=1 every cycle, a_valid=b_valid=0 throughout, drop_cnt ends at 255.
- Reset mid-stall: a_valid=b_valid=1 with ready=0, assert rst for 1 cycle with c_valid=1 -> c_ready=0 during reset; after reset a_valid=b_valid=0, drop_cnt=0, and no beat from the reset cycle appears.
- Random soak: random c_valid/c_dst/a_ready/b_ready for 5000 ns against a scoreboard -> per-output order and data exact, no valid drop or data change while stalled, accepted count equals emitted plus dropped.
